// File: rtl/ber_noise_pkg.sv
// Shared table geometry and sequencer state type for the BER noise source run controller.
package ber_noise_pkg;
    localparam int          NUM_ENTRIES   = 64;
    localparam int          PROB_W        = 64;
    localparam int          IDX_W         = $clog2(NUM_ENTRIES);
    localparam int          STEP_W        = $clog2(NUM_ENTRIES + 1);
    localparam logic [31:0] PROB_IDX_NONE = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEED,
        S_RUN,
        S_DRAIN
    } seq_state_e;
endpackage

// File: rtl/prob_shadow_ram.sv
// Host-writable shadow of the cumulative probability table: one write port,
// one read port with a single cycle of read latency.
module prob_shadow_ram
    import ber_noise_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [PROB_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [PROB_W-1:0] rd_data
);
    logic [PROB_W-1:0] mem [NUM_ENTRIES];

    // NOTE: the array itself is never reset so it can map onto block RAM; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst)        rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/noise_gen_sequencer.sv
// Run controller for the BER noise generator: streams the shadow table and seeds into the
// held-in-reset generator, runs it for a programmed sample count, drains and reports done.
module noise_gen_sequencer
    import ber_noise_pkg::*;
#(
    parameter int CNT_W        = 48,
    parameter int SEED_HOLD    = 2,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_wr_en,
    input  logic [IDX_W-1:0]  cfg_wr_addr,
    input  logic [PROB_W-1:0] cfg_wr_data,
    output logic              cfg_wr_err,
    input  logic [63:0]       seed0,
    input  logic [63:0]       seed1,
    input  logic [63:0]       seed2,
    input  logic [CNT_W-1:0]  num_samples,
    input  logic              start,
    input  logic              abort,
    input  logic              sink_ready,
    output logic              gen_rstn,
    output logic              gen_en,
    output logic [31:0]       gen_prob_idx,
    output logic [PROB_W-1:0] gen_prob_data,
    output logic [63:0]       gen_seed0,
    output logic [63:0]       gen_seed1,
    output logic [63:0]       gen_seed2,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              mono_err,
    output logic [CNT_W-1:0]  sample_count
);
    seq_state_e        state;
    logic [STEP_W-1:0] step;
    logic [CNT_W-1:0]  num_lat;
    logic [PROB_W-1:0] prev_data;
    logic              rd_en;
    logic              take;

    assign rd_en = (state == S_LOAD) && (step < STEP_W'(NUM_ENTRIES));
    // gen_en is a flop, so a sample is granted on the sink_ready seen at the preceding edge.
    assign take  = sink_ready && (sample_count < num_lat);

    // Table data is the RAM read register itself, which lines up with the registered index.
    prob_shadow_ram u_shadow (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (cfg_wr_en && (state == S_IDLE)),
        .wr_addr (cfg_wr_addr),
        .wr_data (cfg_wr_data),
        .rd_en   (rd_en),
        .rd_addr (step[IDX_W-1:0]),
        .rd_data (gen_prob_data)
    );

    // NOTE: non-blocking assignments throughout, so every output is a flop updated from the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            step         <= '0;
            num_lat      <= '0;
            prev_data    <= '0;
            gen_rstn     <= 1'b0;
            gen_en       <= 1'b0;
            gen_prob_idx <= PROB_IDX_NONE;
            gen_seed0    <= '0;
            gen_seed1    <= '0;
            gen_seed2    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            aborted      <= 1'b0;
            mono_err     <= 1'b0;
            sample_count <= '0;
            cfg_wr_err   <= 1'b0;
        end else begin
            done       <= 1'b0;
            cfg_wr_err <= cfg_wr_en && (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    gen_rstn <= 1'b0;
                    gen_en   <= 1'b0;
                    if (start) begin
                        state        <= S_LOAD;
                        busy         <= 1'b1;
                        step         <= '0;
                        num_lat      <= num_samples;
                        gen_seed0    <= seed0;
                        gen_seed1    <= seed1;
                        gen_seed2    <= seed2;
                        sample_count <= '0;
                        aborted      <= 1'b0;
                        mono_err     <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        state        <= S_IDLE;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        aborted      <= 1'b1;
                        gen_prob_idx <= PROB_IDX_NONE;
                    end else begin
                        // Entry step-1 is on the outputs now; compare it with the one before.
                        if (step >= STEP_W'(2) && gen_prob_data < prev_data) mono_err <= 1'b1;
                        prev_data <= gen_prob_data;
                        if (step == STEP_W'(NUM_ENTRIES)) begin
                            state        <= S_SEED;
                            step         <= '0;
                            gen_prob_idx <= PROB_IDX_NONE;
                        end else begin
                            step         <= step + STEP_W'(1);
                            gen_prob_idx <= 32'(step);
                        end
                    end
                end
                S_SEED: begin
                    if (abort) begin
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end else if (step == STEP_W'(SEED_HOLD - 1)) begin
                        state        <= S_RUN;
                        gen_rstn     <= 1'b1;
                        gen_en       <= take;
                        sample_count <= sample_count + CNT_W'(take);
                    end else begin
                        step <= step + STEP_W'(1);
                    end
                end
                S_RUN: begin
                    if (abort || sample_count == num_lat) begin
                        state  <= S_DRAIN;
                        step   <= '0;
                        gen_en <= 1'b0;
                        if (abort) aborted <= 1'b1;
                    end else begin
                        gen_en       <= take;
                        sample_count <= sample_count + CNT_W'(take);
                    end
                end
                S_DRAIN: begin
                    if (step == STEP_W'(DRAIN_CYCLES - 1)) begin
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        gen_rstn <= 1'b0;
                    end else begin
                        step <= step + STEP_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_noise_gen_sequencer.sv
// Directed bench for noise_gen_sequencer: table load scoreboard, run/drain timing,
// backpressure, abort paths, busy-write rejection, monotonicity flag and mid-run reset.
module tb_noise_gen_sequencer;
    import ber_noise_pkg::*;

    localparam int DRAIN_CYCLES = 3;

    typedef struct packed {
        logic [31:0] idx;
        logic [63:0] data;
    } prob_entry_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_wr_en;
    logic [5:0]  cfg_wr_addr;
    logic [63:0] cfg_wr_data;
    logic        cfg_wr_err;
    logic [63:0] seed0, seed1, seed2;
    logic [47:0] num_samples;
    logic        start, abort, sink_ready;
    logic        gen_rstn, gen_en;
    logic [31:0] gen_prob_idx;
    logic [63:0] gen_prob_data;
    logic [63:0] gen_seed0, gen_seed1, gen_seed2;
    logic        busy, done, aborted, mono_err;
    logic [47:0] sample_count;

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] tbl [NUM_ENTRIES];
    prob_entry_t exp_q [$];

    noise_gen_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_wr_en     (cfg_wr_en),
        .cfg_wr_addr   (cfg_wr_addr),
        .cfg_wr_data   (cfg_wr_data),
        .cfg_wr_err    (cfg_wr_err),
        .seed0         (seed0),
        .seed1         (seed1),
        .seed2         (seed2),
        .num_samples   (num_samples),
        .start         (start),
        .abort         (abort),
        .sink_ready    (sink_ready),
        .gen_rstn      (gen_rstn),
        .gen_en        (gen_en),
        .gen_prob_idx  (gen_prob_idx),
        .gen_prob_data (gen_prob_data),
        .gen_seed0     (gen_seed0),
        .gen_seed1     (gen_seed1),
        .gen_seed2     (gen_seed2),
        .busy          (busy),
        .done          (done),
        .aborted       (aborted),
        .mono_err      (mono_err),
        .sample_count  (sample_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int addr, input logic [63:0] data);
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = 6'(addr);
        cfg_wr_data = data;
        tick();
        cfg_wr_en   = 1'b0;
    endtask

    function automatic logic mono_exp();
        for (int k = 1; k < NUM_ENTRIES; k++)
            if (tbl[k] < tbl[k-1]) return 1'b1;
        return 1'b0;
    endfunction

    // One full run: start, 65 LOAD cycles against the scoreboard, SEED, RUN with a
    // registered-grant model, DRAIN and the done pulse.
    task automatic do_run(input string name, input logic [47:0] n, input int mode,
                          input int abort_k, input int wr_at, input int exp_total);
        prob_entry_t e;
        logic [63:0] s0, s1, s2;
        logic [47:0] mcount;
        logic        exp_en, exp_ab, ended, rdy;
        int          k, total;
        s0 = {$urandom, $urandom};
        s1 = {$urandom, $urandom};
        s2 = {$urandom, $urandom};
        seed0 = s0; seed1 = s1; seed2 = s2;
        num_samples = n;
        start = 1'b1;
        for (int j = 0; j < NUM_ENTRIES; j++) begin
            e.idx  = 32'(j);
            e.data = tbl[j];
            exp_q.push_back(e);
        end
        tick();
        start = 1'b0;
        seed0 = ~s0; seed1 = ~s1; seed2 = ~s2;
        num_samples = '1;
        check({name, ".load0_busy"}, busy, 1);
        check({name, ".load0_idx"}, gen_prob_idx, PROB_IDX_NONE);
        check({name, ".load0_aborted"}, aborted, 0);
        check({name, ".load0_mono"}, mono_err, 0);
        check({name, ".load0_count"}, sample_count, 0);

        for (int j = 1; j <= NUM_ENTRIES; j++) begin
            cfg_wr_en   = (j - 1 == wr_at);
            cfg_wr_addr = 6'd20;
            cfg_wr_data = '1;
            tick();
            cfg_wr_en = 1'b0;
            check({name, ".load_wr_err"}, cfg_wr_err, (j - 1 == wr_at));
            check({name, ".load_rstn"}, gen_rstn, 0);
            if (exp_q.size() == 0) begin
                check({name, ".load_queue_empty"}, 1, 0);
            end else begin
                e = exp_q.pop_front();
                check({name, ".load_idx"}, gen_prob_idx, e.idx);
                check({name, ".load_data"}, gen_prob_data, e.data);
            end
        end

        tick();
        check({name, ".seed0_idx"}, gen_prob_idx, PROB_IDX_NONE);
        check({name, ".seed0_rstn"}, gen_rstn, 0);
        check({name, ".mono_err"}, mono_err, mono_exp());
        tick();
        check({name, ".seed1_rstn"}, gen_rstn, 0);
        check({name, ".seed0_latched"}, gen_seed0, s0);
        check({name, ".seed1_latched"}, gen_seed1, s1);
        check({name, ".seed2_latched"}, gen_seed2, s2);

        mcount = '0; k = 0; ended = 1'b0; exp_ab = 1'b0; total = 0;
        while (!ended) begin
            rdy        = (mode == 0) ? 1'b1 : (k % 2 == 1);
            sink_ready = rdy;
            abort      = (k > 0) && (k == abort_k);
            if (k > 0 && (abort || mcount == n)) begin
                ended  = 1'b1;
                exp_en = 1'b0;
                exp_ab = abort;
            end else begin
                exp_en = rdy && (mcount < n);
                mcount = mcount + 48'(exp_en);
            end
            tick();
            abort = 1'b0;
            check({name, ".run_gen_en"}, gen_en, exp_en);
            check({name, ".run_count"}, sample_count, mcount);
            check({name, ".run_rstn"}, gen_rstn, 1);
            check({name, ".run_done"}, done, 0);
            total += int'(gen_en);
            k++;
        end

        sink_ready = 1'b1;
        for (int d = 1; d < DRAIN_CYCLES; d++) begin
            tick();
            check({name, ".drain_gen_en"}, gen_en, 0);
            check({name, ".drain_rstn"}, gen_rstn, 1);
            check({name, ".drain_done"}, done, 0);
            check({name, ".drain_busy"}, busy, 1);
        end
        tick();
        check({name, ".done"}, done, 1);
        check({name, ".end_busy"}, busy, 0);
        check({name, ".end_rstn"}, gen_rstn, 0);
        check({name, ".aborted"}, aborted, exp_ab);
        check({name, ".final_count"}, sample_count, mcount);
        check({name, ".gen_en_total"}, 64'(total), 64'(exp_total));
        tick();
        check({name, ".done_pulse"}, done, 0);
    endtask

    initial begin
        int waited;
        rst = 1'b1; cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
        seed0 = '0; seed1 = '0; seed2 = '0; num_samples = '0;
        start = 1'b0; abort = 1'b0; sink_ready = 1'b0;
        tick();
        tick();
        check("rst.gen_rstn", gen_rstn, 0);
        check("rst.gen_en", gen_en, 0);
        check("rst.idx", gen_prob_idx, PROB_IDX_NONE);
        check("rst.data", gen_prob_data, 0);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.aborted", aborted, 0);
        check("rst.mono_err", mono_err, 0);
        check("rst.count", sample_count, 0);
        check("rst.wr_err", cfg_wr_err, 0);
        rst = 1'b0;

        for (int k = 0; k < NUM_ENTRIES; k++) begin
            tbl[k] = 64'(k) << 57;
            wr(k, tbl[k]);
        end
        check("idle_write.wr_err", cfg_wr_err, 0);

        do_run("t1", 48'd10, 0, -1, -1, 10);
        do_run("t2", 48'd5, 1, -1, -1, 5);
        do_run("t3", 48'd0, 0, -1, -1, 0);
        do_run("t4", 48'd100, 0, 3, -1, 3);

        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_abort.busy", busy, 0);
        check("idle_abort.done", done, 0);

        num_samples = 48'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("load_abort.done", done, 1);
        check("load_abort.aborted", aborted, 1);
        check("load_abort.busy", busy, 0);
        check("load_abort.rstn", gen_rstn, 0);
        check("load_abort.idx", gen_prob_idx, PROB_IDX_NONE);
        tick();
        check("load_abort.done_pulse", done, 0);
        check("load_abort.sticky", aborted, 1);

        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("start_wins.busy", busy, 1);
        check("start_wins.aborted", aborted, 0);
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("load_abort2.done", done, 1);
        check("load_abort2.aborted", aborted, 1);
        tick();

        do_run("t5a", 48'd2, 0, -1, 5, 2);

        tbl[5] = tbl[4] - 64'd1;
        wr(5, tbl[5]);
        do_run("t5b", 48'd1, 0, -1, -1, 1);
        tbl[5] = 64'(5) << 57;
        wr(5, tbl[5]);
        do_run("t5c", 48'd1, 0, -1, -1, 1);

        num_samples = 48'd100; sink_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        waited = 0;
        while (gen_en !== 1'b1 && waited < 200) begin
            tick();
            waited++;
        end
        check("t6.reach_run", gen_en, 1);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("t6.rst_rstn", gen_rstn, 0);
        check("t6.rst_gen_en", gen_en, 0);
        check("t6.rst_busy", busy, 0);
        check("t6.rst_count", sample_count, 0);
        check("t6.rst_idx", gen_prob_idx, PROB_IDX_NONE);
        rst = 1'b0;
        tick();
        do_run("t6", 48'd4, 0, -1, -1, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
